// File: rtl/ttl_or_reduce.sv
// Per-channel OR reduction for the parametrised OR-gate family.
// Input j of channel i lives at A_2D[j*BLOCKS+i], matching the existing gate models.
module ttl_or_reduce #(
  parameter int BLOCKS   = 4,
  parameter int WIDTH_IN = 2
) (
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic [BLOCKS-1:0]          G
);

  always_comb begin
    G = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      for (int j = 0; j < WIDTH_IN; j++) begin
        G[i] = G[i] | A_2D[j*BLOCKS+i];
      end
    end
  end

endmodule

// File: rtl/ttl_or_sticky_register.sv
// Multi-channel OR feeding a clocked register that is either plain or a 74279-style
// sticky set-latch, with rise pulses, an any-set flag and a lowest-index priority output.
module ttl_or_sticky_register #(
  parameter int BLOCKS     = 4,
  parameter int WIDTH_IN   = 2,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0,
  localparam int IDX_W     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
  input  logic                       Clk,
  input  logic                       Clear,
  input  logic                       Enable,
  input  logic                       Sticky,
  input  logic [BLOCKS-1:0]          Ack,
  input  logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic [BLOCKS-1:0]          Y,
  output logic [BLOCKS-1:0]          Rise,
  output logic                       Any,
  output logic [IDX_W-1:0]           First,
  output logic                       First_Valid
);

  logic [BLOCKS-1:0] g;
  logic [BLOCKS-1:0] q;
  logic [BLOCKS-1:0] r;
  logic [BLOCKS-1:0] q_next;
  logic [IDX_W-1:0]  first_c;
  logic              any_c;

  ttl_or_reduce #(
    .BLOCKS   (BLOCKS),
    .WIDTH_IN (WIDTH_IN)
  ) u_reduce (
    .A_2D (A_2D),
    .G    (g)
  );

  // In sticky mode a set input wins over Ack on the same edge.
  always_comb begin
    q_next = g;
    if (Sticky) begin
      q_next = (q & ~Ack) | g;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      q <= '0;
      r <= '0;
    end else if (!Enable) begin
      r <= '0;
    end else begin
      q <= q_next;
      r <= ~q & q_next;
    end
  end

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    first_c = '0;
    for (int i = BLOCKS - 1; i >= 0; i--) begin
      if (q[i]) begin
        first_c = IDX_W'(i);
      end
    end
  end

  assign any_c = |q;

  assign #(DELAY_RISE, DELAY_FALL) Y           = q;
  assign #(DELAY_RISE, DELAY_FALL) Rise        = r;
  assign #(DELAY_RISE, DELAY_FALL) Any         = any_c;
  assign #(DELAY_RISE, DELAY_FALL) First       = first_c;
  assign #(DELAY_RISE, DELAY_FALL) First_Valid = any_c;

endmodule

// File: tb/tb_ttl_or_sticky_register.sv
// Directed bench for ttl_or_sticky_register with BLOCKS=5, WIDTH_IN=2 and output delays 5/3.
module tb_ttl_or_sticky_register;

  localparam int BLOCKS   = 5;
  localparam int WIDTH_IN = 2;
  localparam int IDX_W    = 3;

  logic                       clk;
  logic                       clear;
  logic                       enable;
  logic                       sticky;
  logic [BLOCKS-1:0]          ack;
  logic [BLOCKS*WIDTH_IN-1:0] a_2d;
  logic [BLOCKS-1:0]          y;
  logic [BLOCKS-1:0]          rise;
  logic                       any;
  logic [IDX_W-1:0]           first;
  logic                       first_valid;

  logic [BLOCKS-1:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  ttl_or_sticky_register #(
    .BLOCKS     (BLOCKS),
    .WIDTH_IN   (WIDTH_IN),
    .DELAY_RISE (5),
    .DELAY_FALL (3)
  ) dut (
    .Clk         (clk),
    .Clear       (clear),
    .Enable      (enable),
    .Sticky      (sticky),
    .Ack         (ack),
    .A_2D        (a_2d),
    .Y           (y),
    .Rise        (rise),
    .Any         (any),
    .First       (first),
    .First_Valid (first_valid)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Driver: apply inputs for the next edge and record the Y expected after it.
  task automatic drive(input logic clr, input logic en, input logic st,
                       input logic [4:0] ak, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] exp_y);
    clear  = clr;
    enable = en;
    sticky = st;
    ack    = ak;
    a_2d   = {b, a};
    exp_q.push_back(exp_y);
  endtask

  // Wait for the edge plus settling, then score Y against the queued expectation.
  task automatic tick(input string tag);
    logic [4:0] e;
    @(posedge clk);
    #6;
    e = exp_q.pop_front();
    chk(tag, 32'(y), 32'(e));
  endtask

  initial begin
    clear  = 1'b0;
    enable = 1'b0;
    sticky = 1'b0;
    ack    = '0;
    a_2d   = '0;

    // Reset with all inputs high
    drive(1, 0, 0, 5'b00000, 5'b11111, 5'b11111, 5'b00000);
    tick("reset_y");
    chk("reset_rise", 32'(rise), 32'h0);
    chk("reset_any", 32'(any), 32'h0);
    chk("reset_first", 32'(first), 32'h0);
    chk("reset_fv", 32'(first_valid), 32'h0);

    // Plain registered OR
    drive(0, 1, 0, 5'b00000, 5'b01010, 5'b11000, 5'b11010);
    tick("plain_y");
    chk("plain_rise", 32'(rise), 32'h1A);
    chk("plain_first", 32'(first), 32'h1);
    chk("plain_any", 32'(any), 32'h1);
    drive(0, 1, 0, 5'b00000, 5'b01010, 5'b11000, 5'b11010);
    tick("plain_hold_y");
    chk("plain_single_pulse", 32'(rise), 32'h0);
    drive(0, 1, 0, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
    tick("plain_drop_y");

    // Sticky latch held after input pulse, released by Ack
    drive(0, 1, 1, 5'b00000, 5'b00100, 5'b00000, 5'b00100);
    tick("sticky_set_y");
    chk("sticky_set_rise", 32'(rise), 32'h04);
    chk("sticky_set_first", 32'(first), 32'h2);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00100);
      tick("sticky_hold_y");
    end
    chk("sticky_hold_rise", 32'(rise), 32'h0);
    drive(0, 1, 1, 5'b00100, 5'b00000, 5'b00000, 5'b00000);
    tick("sticky_ack_y");
    chk("sticky_ack_any", 32'(any), 32'h0);
    chk("sticky_ack_fv", 32'(first_valid), 32'h0);

    // Set wins over Ack on the same edge
    drive(0, 1, 1, 5'b00000, 5'b00001, 5'b00000, 5'b00001);
    tick("setack_pre_y");
    drive(0, 1, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00001);
    tick("setack_y");
    chk("setack_no_rise", 32'(rise), 32'h0);
    drive(0, 1, 1, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
    tick("ack_all_y");

    // Sticky 1->0 drops latched bits that are no longer driven
    drive(0, 1, 1, 5'b00000, 5'b00010, 5'b00000, 5'b00010);
    tick("mode_latch_y");
    drive(0, 1, 1, 5'b00000, 5'b00000, 5'b01000, 5'b01010);
    tick("mode_accum_y");
    chk("mode_accum_rise", 32'(rise), 32'h08);
    chk("mode_accum_first", 32'(first), 32'h1);
    drive(0, 1, 0, 5'b00000, 5'b00000, 5'b01000, 5'b01000);
    tick("mode_plain_y");
    chk("mode_plain_first", 32'(first), 32'h3);

    // Enable low holds Y and suppresses Rise; Clear overrides Enable
    drive(0, 1, 0, 5'b00000, 5'b00111, 5'b10101, 5'b10111);
    tick("en_load_y");
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b10111);
      tick("en_hold_y");
      chk("en_hold_rise", 32'(rise), 32'h0);
    end
    drive(1, 0, 1, 5'b11111, 5'b11111, 5'b11111, 5'b00000);
    tick("clear_while_disabled_y");
    chk("clear_any", 32'(any), 32'h0);

    // Output delay: nothing visible at +2, settled at +6
    drive(0, 1, 0, 5'b00000, 5'b00111, 5'b10101, 5'b10111);
    @(posedge clk);
    #2;
    chk("timing_early_y", 32'(y), 32'h0);
    #4;
    chk("timing_late_y", 32'(y), 32'(exp_q.pop_front()));
    chk("timing_first", 32'(first), 32'h0);
    chk("timing_any", 32'(any), 32'h1);
    chk("timing_fv", 32'(first_valid), 32'h1);
    chk("timing_rise", 32'(rise), 32'h17);

    // Clear mid sticky operation, then fresh start
    sticky = 1'b1;
    drive(1, 1, 1, 5'b00000, 5'b11111, 5'b00000, 5'b00000);
    tick("clear_mid_y");
    drive(0, 1, 1, 5'b00000, 5'b10000, 5'b00000, 5'b10000);
    tick("fresh_y");
    chk("fresh_rise", 32'(rise), 32'h10);
    chk("fresh_first", 32'(first), 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
